// File: rtl/mod_counter_chain_pkg.sv
// Shared types for the mixed-radix counter chain.
// Holds the per-edge action select used by every digit and the top.
package mod_counter_chain_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_COUNT,
        ACT_LOAD,
        ACT_CLEAR
    } act_e;

    // Clear beats Load beats counting.
    function automatic act_e sel_act(logic clear, logic load, logic adv);
        act_e a;
        a = ACT_HOLD;
        if (clear) a = ACT_CLEAR;
        else if (load) a = ACT_LOAD;
        else if (adv) a = ACT_COUNT;
        return a;
    endfunction

endpackage

// File: rtl/mod_counter_chain_digit.sv
// One modulo-(MAXV+1) digit with up/down count, clamped load and
// a registered wrap pulse.
module mod_counter_digit
    import mod_counter_chain_pkg::*;
#(
    parameter int              W    = 4,
    parameter logic [W-1:0]    MAXV = '1
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Clear,
    input  logic         Load,
    input  logic [W-1:0] D,
    input  logic         Adv,
    input  logic         Up,
    output logic [W-1:0] Q,
    output logic         Term,
    output logic         Carry
);

    logic [W-1:0] q_q, q_d;
    logic         carry_q, carry_d;
    act_e         act;

    assign Term = Up ? (q_q == MAXV) : (q_q == '0);
    assign act  = sel_act(Clear, Load, Adv);

    always_comb begin
        q_d     = q_q;
        carry_d = 1'b0;
        unique case (act)
            ACT_CLEAR: q_d = '0;
            ACT_LOAD:  q_d = (D > MAXV) ? MAXV : D;
            ACT_COUNT: begin
                carry_d = Term;
                if (Term) q_d = Up ? '0 : MAXV;
                else      q_d = Up ? q_q + W'(1) : q_q - W'(1);
            end
            ACT_HOLD:  q_d = q_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            q_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign Q     = q_q;
    assign Carry = carry_q;

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of STAGES modulo digits with ripple advance, per-digit
// wrap pulses and a sticky whole-chain overflow flag.
module mod_counter_chain
    import mod_counter_chain_pkg::*;
#(
    parameter int                     STAGES = 4,
    parameter int                     W      = 4,
    parameter logic [STAGES*W-1:0]    MAXV   = 16'h9999
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Enable,
    input  logic                Up,
    input  logic                Clear,
    input  logic                Load,
    input  logic [STAGES*W-1:0] D,
    output logic [STAGES*W-1:0] Q,
    output logic [STAGES-1:0]   Carry,
    output logic                Ovf
);

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] term;
    logic              ovf_q, ovf_d;
    act_e              act;

    // Advance ripples through every terminal digit within one cycle.
    always_comb begin
        adv[0] = Enable;
        for (int i = 1; i < STAGES; i++) begin
            adv[i] = adv[i-1] & term[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_digit
        mod_counter_digit #(
            .W    (W),
            .MAXV (MAXV[g*W +: W])
        ) u_digit (
            .Clock   (Clock),
            .Reset_n (Reset_n),
            .Clear   (Clear),
            .Load    (Load),
            .D       (D[g*W +: W]),
            .Adv     (adv[g]),
            .Up      (Up),
            .Q       (Q[g*W +: W]),
            .Term    (term[g]),
            .Carry   (Carry[g])
        );
    end

    assign act = sel_act(Clear, Load, Enable);

    always_comb begin
        ovf_d = ovf_q;
        unique case (act)
            ACT_CLEAR, ACT_LOAD: ovf_d = 1'b0;
            ACT_COUNT: ovf_d = ovf_q | (adv[STAGES-1] & term[STAGES-1]);
            ACT_HOLD:  ovf_d = ovf_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign Ovf = ovf_q;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Bench for mod_counter_chain: mm:ss and default BCD instances driven
// together and compared against a mixed-radix integer model.
module tb_mod_counter_chain;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Enable = 1'b0;
    logic        Up = 1'b1;
    logic        Clear = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] D = '0;
    logic [15:0] q0, q1;
    logic [3:0]  c0, c1;
    logic        o0, o1;

    int checks = 0;
    int errors = 0;

    int          rad [2][4];
    int          mn  [2];
    logic [3:0]  mc  [2];
    logic        mo  [2];

    always #5 Clock = ~Clock;

    mod_counter_chain #(.STAGES(4), .W(4), .MAXV(16'h5959)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Up(Up),
        .Clear(Clear), .Load(Load), .D(D), .Q(q0), .Carry(c0), .Ovf(o0)
    );

    mod_counter_chain dut_d (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Up(Up),
        .Clear(Clear), .Load(Load), .D(D), .Q(q1), .Carry(c1), .Ovf(o1)
    );

    // Count value as a plain integer, rendered into packed digits.
    function automatic logic [15:0] to_q(int c, int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(n % rad[c][i]);
            n = n / rad[c][i];
        end
        return r;
    endfunction

    function automatic int from_d(int c, logic [15:0] d);
        int n, w, dg;
        n = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            dg = int'(d[i*4 +: 4]);
            if (dg > rad[c][i] - 1) dg = rad[c][i] - 1;
            n += dg * w;
            w *= rad[c][i];
        end
        return n;
    endfunction

    task automatic step(int c);
        int p;
        if (Clear) begin
            mn[c] = 0; mc[c] = '0; mo[c] = 1'b0;
        end else if (Load) begin
            mn[c] = from_d(c, D); mc[c] = '0; mo[c] = 1'b0;
        end else if (Enable) begin
            p = 1;
            mc[c] = '0;
            // Digit i wraps when the low i+1 digits form a whole period.
            for (int i = 0; i < 4; i++) begin
                p *= rad[c][i];
                if (Up) mc[c][i] = ((mn[c] + 1) % p) == 0;
                else    mc[c][i] = (mn[c] % p) == 0;
            end
            mn[c] = Up ? (mn[c] + 1) % p : (mn[c] + p - 1) % p;
            mo[c] = mo[c] | mc[c][3];
        end else begin
            mc[c] = '0;
        end
    endtask

    task automatic cmp(string tag, logic [15:0] got, logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk(string tag);
        cmp({tag, ".q"},    q0, to_q(0, mn[0]));
        cmp({tag, ".c"},    16'(c0), 16'(mc[0]));
        cmp({tag, ".o"},    16'(o0), 16'(mo[0]));
        cmp({tag, ".dq"},   q1, to_q(1, mn[1]));
        cmp({tag, ".dc"},   16'(c1), 16'(mc[1]));
        cmp({tag, ".do"},   16'(o1), 16'(mo[1]));
    endtask

    task automatic cyc(string tag);
        @(posedge Clock);
        step(0);
        step(1);
        @(negedge Clock);
        chk(tag);
    endtask

    task automatic mreset();
        for (int c = 0; c < 2; c++) begin
            mn[c] = 0; mc[c] = '0; mo[c] = 1'b0;
        end
    endtask

    initial begin
        rad[0][0] = 10; rad[0][1] = 6; rad[0][2] = 10; rad[0][3] = 6;
        for (int i = 0; i < 4; i++) rad[1][i] = 10;
        mreset();

        #12;
        chk("rst");
        @(negedge Clock);
        Reset_n = 1'b1;

        // Async reset in the middle of counting.
        Load = 1'b1; D = 16'h1234;
        cyc("ld1234");
        Load = 1'b0; Enable = 1'b1; Up = 1'b1;
        cyc("cnt1");
        cmp("pre_rst", q0, 16'h1235);
        #2 Reset_n = 1'b0;
        mreset();
        #1 chk("async_rst");
        cmp("async_rst_q", q0, 16'h0000);
        @(negedge Clock);
        Reset_n = 1'b1; Enable = 1'b0;
        repeat (2) cyc("hold_after_rst");

        // Ten up-counts across the first digit boundary.
        Clear = 1'b1;
        cyc("clr2");
        Clear = 1'b0; Enable = 1'b1; Up = 1'b1;
        repeat (9) cyc("up9");
        cmp("up9_q", q0, 16'h0009);
        cyc("up10");
        cmp("up10_q", q0, 16'h0010);
        cmp("up10_c", 16'(c0), 16'h0001);
        cyc("up11");
        cmp("up11_c", 16'(c0), 16'h0000);

        // Full-chain wrap going up.
        Enable = 1'b0; Load = 1'b1; D = 16'h5958;
        cyc("ld5958");
        Load = 1'b0; Enable = 1'b1;
        cyc("to5959");
        cmp("to5959_q", q0, 16'h5959);
        cyc("wrap_up");
        cmp("wrap_up_q", q0, 16'h0000);
        cmp("wrap_up_c", 16'(c0), 16'h000f);
        cmp("wrap_up_o", 16'(o0), 16'h0001);
        Enable = 1'b0;
        repeat (3) cyc("ovf_sticky");
        cmp("ovf_sticky_o", 16'(o0), 16'h0001);

        // Full-chain wrap going down.
        Clear = 1'b1;
        cyc("clr4");
        Clear = 1'b0; Enable = 1'b1; Up = 1'b0;
        cyc("wrap_dn");
        cmp("wrap_dn_q", q0, 16'h5959);
        cmp("wrap_dn_c", 16'(c0), 16'h000f);
        cmp("wrap_dn_o", 16'(o0), 16'h0001);
        cyc("dn1");
        cmp("dn1_q", q0, 16'h5958);
        cmp("dn1_c", 16'(c0), 16'h0000);

        // Clamped load clears overflow.
        Enable = 1'b0; Load = 1'b1; D = 16'h7a3c;
        cyc("ld_clamp");
        cmp("ld_clamp_q", q0, 16'h5939);
        cmp("ld_clamp_dq", q1, 16'h7939);
        cmp("ld_clamp_o", 16'(o0), 16'h0000);

        // Clear beats Load beats Enable.
        Clear = 1'b1; Load = 1'b1; Enable = 1'b1; Up = 1'b1;
        cyc("prio");
        cmp("prio_q", q0, 16'h0000);
        Clear = 1'b0; Load = 1'b0; Enable = 1'b0;
        repeat (5) cyc("idle5");
        cmp("idle5_q", q0, 16'h0000);

        // Default BCD instance wrapping from 9999.
        Load = 1'b1; D = 16'h9999;
        cyc("ld9999");
        Load = 1'b0; Enable = 1'b1; Up = 1'b1;
        cyc("bcd_wrap");
        cmp("bcd_wrap_q", q1, 16'h0000);
        cmp("bcd_wrap_o", 16'(o1), 16'h0001);

        // Random mix of operations against the model.
        for (int k = 0; k < 400; k++) begin
            Clear  = ($urandom_range(0, 29) == 0);
            Load   = ($urandom_range(0, 14) == 0);
            Enable = ($urandom_range(0, 9) < 8);
            Up     = ($urandom_range(0, 3) != 0);
            D      = 16'($urandom);
            cyc("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
